// File: rtl/counter_sequencer.sv
// Sequencer for an external load/enable/dec up-down counter: loads a start value, steps it once
// every PRESCALE clocks until it matches a limit, then pulses done. Supports pause and abort.
module counter_sequencer #(
  parameter int unsigned N        = 64,
  parameter int unsigned PRESCALE = 4
) (
  input  logic         clock,
  input  logic         reset,
  input  logic         start,
  input  logic         pause,
  input  logic         abort,
  input  logic         dir,
  input  logic [N-1:0] init_value,
  input  logic [N-1:0] limit_value,
  input  logic [N-1:0] cnt_value,
  output logic         cnt_load,
  output logic [N-1:0] cnt_load_value,
  output logic         cnt_enable,
  output logic         cnt_dec,
  output logic         busy,
  output logic         done
);

  localparam int unsigned PsW = (PRESCALE > 1) ? $clog2(PRESCALE) : 1;
  localparam logic [PsW-1:0] PsLast = PsW'(PRESCALE - 1);

  typedef enum logic [2:0] {StIdle, StLoad, StRun, StPause, StDone} state_e;

  state_e         state_q, state_d;
  logic [PsW-1:0] ps_q, ps_d;
  logic           dir_q, dir_d;
  logic [N-1:0]   init_q, init_d;
  logic [N-1:0]   limit_q, limit_d;

  always_ff @(posedge clock) begin
    if (reset) begin
      state_q <= StIdle;
      ps_q    <= '0;
      dir_q   <= 1'b0;
      init_q  <= '0;
      limit_q <= '0;
    end else begin
      state_q <= state_d;
      ps_q    <= ps_d;
      dir_q   <= dir_d;
      init_q  <= init_d;
      limit_q <= limit_d;
    end
  end

  always_comb begin
    state_d    = state_q;
    ps_d       = ps_q;
    dir_d      = dir_q;
    init_d     = init_q;
    limit_d    = limit_q;
    cnt_load   = 1'b0;
    cnt_enable = 1'b0;
    done       = 1'b0;
    // Reset and abort both suppress every strobe in the cycle they are seen.
    if (reset) begin
      state_d = StIdle;
    end else if (abort) begin
      state_d = StIdle;
    end else begin
      unique case (state_q)
        StIdle: begin
          if (start) begin
            dir_d   = dir;
            init_d  = init_value;
            limit_d = limit_value;
            state_d = StLoad;
          end
        end
        StLoad: begin
          cnt_load = 1'b1;
          ps_d     = '0;
          state_d  = StRun;
        end
        StRun: begin
          if (cnt_value == limit_q) begin
            state_d = StDone;
          end else if (pause) begin
            state_d = StPause;
          end else if (ps_q == PsLast) begin
            cnt_enable = 1'b1;
            ps_d       = '0;
          end else begin
            ps_d = ps_q + 1'b1;
          end
        end
        StPause: begin
          if (!pause) state_d = StRun;
        end
        StDone: begin
          done    = 1'b1;
          state_d = StIdle;
        end
        default: state_d = StIdle;
      endcase
    end
  end

  assign busy           = (state_q != StIdle);
  assign cnt_dec        = busy & dir_q;
  assign cnt_load_value = init_q;

endmodule

// File: tb/tb_counter_sequencer.sv
// Randomized self-checking bench for counter_sequencer; expected event cycles come from the
// step-count arithmetic (enable at 1+k*P, done at 3+steps*P) shifted by any pause window.
module tb_counter_sequencer;
  localparam int unsigned N = 64;
  localparam int unsigned P = 4;

  logic         clock = 1'b0;
  logic         reset, start, pause, abort, dir;
  logic [N-1:0] init_value, limit_value, cnt_value;
  logic         cnt_load, cnt_enable, cnt_dec, busy, done;
  logic [N-1:0] cnt_load_value;

  int n_cmp = 0;
  int n_err = 0;
  int cyc   = 0;

  always #5 clock = ~clock;

  counter_sequencer #(.N(N), .PRESCALE(P)) dut (
    .clock          (clock),
    .reset          (reset),
    .start          (start),
    .pause          (pause),
    .abort          (abort),
    .dir            (dir),
    .init_value     (init_value),
    .limit_value    (limit_value),
    .cnt_value      (cnt_value),
    .cnt_load       (cnt_load),
    .cnt_load_value (cnt_load_value),
    .cnt_enable     (cnt_enable),
    .cnt_dec        (cnt_dec),
    .busy           (busy),
    .done           (done)
  );

  // The counter being controlled.
  always_ff @(posedge clock) begin
    if (reset)           cnt_value <= '0;
    else if (cnt_load)   cnt_value <= cnt_load_value;
    else if (cnt_enable) cnt_value <= cnt_dec ? cnt_value - 1'b1 : cnt_value + 1'b1;
  end

  task automatic check_eq(input string tag, input logic [N-1:0] got, input logic [N-1:0] exp);
    n_cmp++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s cyc=%0d got=%0h exp=%0h", tag, cyc, got, exp);
    end
  endtask

  // A pause first seen in RUN cycle pa and held pl cycles stalls progress for pl+1 cycles.
  function automatic int eff(input int x, input int pa, input int pl);
    if (pa >= 0 && x >= pa) return x + pl + 1;
    return x;
  endfunction

  task automatic idle_inputs();
    start = 1'b0; pause = 1'b0; abort = 1'b0; reset = 1'b0;
  endtask

  // Cycle 0 is the cycle in which start is high.
  task automatic run_seq(input logic [N-1:0] iv, input logic [N-1:0] lv, input logic d,
                         input int pa, input int pl, input int ab, input int rs, input bit junk);
    logic [N-1:0] st;
    int stp, dn;
    bit ended;
    logic e_en, e_ld, e_dn, e_bz;
    st    = d ? (iv - lv) : (lv - iv);
    stp   = int'(st);
    dn    = eff(3 + stp * int'(P), pa, pl);
    ended = 1'b0;
    for (int c = 0; c <= dn + 2; c++) begin
      cyc   = c;
      start = (c == 0) || (junk && !ended && c <= dn && $urandom_range(0, 3) == 0);
      if (c == 0 || !junk) begin
        init_value = iv; limit_value = lv; dir = d;
      end else begin
        init_value = {$urandom, $urandom}; limit_value = {$urandom, $urandom};
        dir = 1'($urandom);
      end
      pause = (pa >= 0 && c >= pa && c < pa + pl);
      abort = (c == ab);
      reset = (c == rs);
      if (ended) start = 1'b0;
      @(negedge clock);
      e_en = 1'b0;
      for (int k = 1; k <= stp; k++) if (eff(1 + k * int'(P), pa, pl) == c) e_en = 1'b1;
      e_ld = (c == 1);
      e_dn = (c == dn);
      e_bz = (c >= 1 && c <= dn);
      if (c == ab) begin
        e_en = 1'b0; e_ld = 1'b0; e_dn = 1'b0;
      end
      if (ended) begin
        e_en = 1'b0; e_ld = 1'b0; e_dn = 1'b0; e_bz = 1'b0;
      end
      if (c != rs) begin
        check_eq("cnt_enable", N'(cnt_enable), N'(e_en));
        check_eq("cnt_load", N'(cnt_load), N'(e_ld));
        check_eq("done", N'(done), N'(e_dn));
        check_eq("busy", N'(busy), N'(e_bz));
        check_eq("cnt_dec", N'(cnt_dec), N'(e_bz & d));
        if (e_bz) check_eq("cnt_load_value", cnt_load_value, iv);
        if (e_dn) check_eq("cnt_at_done", cnt_value, lv);
      end
      if (c == ab || c == rs) ended = 1'b1;
      @(posedge clock); #1;
    end
    idle_inputs();
    repeat (2) @(posedge clock);
    #1;
  endtask

  initial begin
    logic [N-1:0] iv, lv;
    logic d;
    int stp, pa, pl, ab, dn;
    idle_inputs();
    reset = 1'b1; dir = 1'b0; init_value = '0; limit_value = '0;
    repeat (3) @(posedge clock);
    #1 reset = 1'b0;
    for (int i = 0; i < 3; i++) begin
      cyc = -1;
      @(negedge clock);
      check_eq("rst_busy", N'(busy), '0);
      check_eq("rst_done", N'(done), '0);
      check_eq("rst_load", N'(cnt_load), '0);
      check_eq("rst_enable", N'(cnt_enable), '0);
      check_eq("rst_dec", N'(cnt_dec), '0);
      check_eq("rst_load_value", cnt_load_value, '0);
      @(posedge clock); #1;
    end

    run_seq(N'(5), N'(8), 1'b0, -1, 0, -1, -1, 1'b0);
    run_seq(N'(1), '1, 1'b1, -1, 0, -1, -1, 1'b0);
    run_seq(N'(42), N'(42), 1'b0, -1, 0, -1, -1, 1'b0);
    run_seq(N'(5), N'(8), 1'b0, 6, 10, -1, -1, 1'b0);
    run_seq(N'(100), N'(96), 1'b1, -1, 0, 7, -1, 1'b0);
    run_seq(N'(5), N'(8), 1'b0, -1, 0, -1, -1, 1'b1);
    run_seq(N'(20), N'(25), 1'b0, -1, 0, -1, 8, 1'b0);

    for (int r = 0; r < 16; r++) begin
      iv  = {$urandom, $urandom};
      d   = 1'($urandom);
      stp = $urandom_range(0, 5);
      lv  = d ? iv - N'(stp) : iv + N'(stp);
      pa  = -1; pl = 0; ab = -1;
      if (stp > 0 && r % 3 == 1) begin
        pa = $urandom_range(2, 1 + stp * int'(P));
        pl = $urandom_range(1, 12);
      end
      if (r % 3 == 2) begin
        dn = 3 + stp * int'(P);
        ab = $urandom_range(1, dn);
      end
      run_seq(iv, lv, d, pa, pl, ab, -1, 1'b1);
    end

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end
endmodule
